// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - byte stream handshake between the UART receiver FIFO and its consumer
interface uart_rx_fifo_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a first-word-fall-through byte FIFO
module uart_rx_fifo #(
  parameter int CPB   = 434,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic                     rx,
  uart_rx_fifo_if.master           m,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     frame_err,
  output logic                     par_err,
  output logic                     overrun
);

  localparam int CCW = $clog2(CPB);
  localparam int AW  = $clog2(DEPTH);
  localparam int NW  = AW + 1;
  localparam logic [CCW-1:0] CLK_LAST = CCW'(CPB - 1);
  localparam logic [CCW-1:0] CLK_HALF = CCW'(CPB / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  logic           rx_meta_q, rx_s_q;
  state_t         state_q, state_d;
  logic [CCW-1:0] cnt_clk_q, cnt_clk_d;
  logic [2:0]     cnt_bit_q, cnt_bit_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           push_q, push_d;
  logic           frame_err_q, frame_err_d;
  logic           bit_end;
`ifdef UART_RX_PARITY_EN
  logic           par_bad_q, par_bad_d;
  logic           par_err_q, par_err_d;
`endif

  logic [7:0]     mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q, rd_next;
  logic [NW-1:0]  count_q, count_d;
  logic           m_valid_q, overrun_q;
  logic [7:0]     m_data_q, head_d;
  logic           do_push, do_pop;

  always_ff @(posedge clock) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_clk_q   <= '0;
      cnt_bit_q   <= '0;
      shreg_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      cnt_clk_q   <= cnt_clk_d;
      cnt_bit_q   <= cnt_bit_d;
      shreg_q     <= shreg_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q   <= par_bad_d;
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign bit_end = (cnt_clk_q == CLK_LAST);

  always_comb begin
    state_d     = state_q;
    cnt_clk_d   = cnt_clk_q;
    cnt_bit_d   = cnt_bit_q;
    shreg_d     = shreg_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
    par_err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_clk_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_clk_q == CLK_HALF) begin
          cnt_clk_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            cnt_bit_d = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end
        end else begin
          cnt_clk_d = cnt_clk_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d   = {rx_s_q, shreg_q[7:1]};
          cnt_clk_d = '0;
          cnt_bit_d = cnt_bit_q + 3'd1;
          if (cnt_bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_clk_d = cnt_clk_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cnt_clk_d = '0;
          par_bad_d = ^shreg_q ^ rx_s_q;
          state_d   = S_STOP;
        end else begin
          cnt_clk_d = cnt_clk_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          cnt_clk_d = '0;
          if (!rx_s_q) begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad_q) begin
            par_err_d = 1'b1;
            state_d   = S_IDLE;
`endif
          end else begin
            push_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          cnt_clk_d = cnt_clk_q + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // shreg_q is stable for at least half a bit after STOP, so the registered push can still use it
  always_comb begin
    do_pop  = m_valid_q & m.m_ready;
    do_push = push_q & ((count_q != NW'(DEPTH)) | do_pop);
    rd_next = rd_ptr_q + AW'(do_pop);
    count_d = count_q + NW'(do_push) - NW'(do_pop);
    head_d  = (do_push && (count_q == NW'(do_pop))) ? shreg_q : mem_q[rd_next];
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= shreg_q;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      rd_ptr_q  <= rd_next;
      count_q   <= count_d;
      m_valid_q <= (count_d != '0);
      if (count_d != '0) m_data_q <= head_d;
      if (push_q && !do_push) overrun_q <= 1'b1;
    end
  end

  assign m.m_data  = m_data_q;
  assign m.m_valid = m_valid_q;
  assign count     = count_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign par_err   = par_err_q;
`else
  assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - randomized self-checking bench for uart_rx_fifo against a byte-queue model
module tb_uart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LATENCY = 2 + CPB / 2 + (8 + P) * CPB + CPB + 1;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  logic rx    = 1'b1;
  logic [$clog2(DEPTH):0] count;
  logic frame_err, par_err, overrun;

  uart_rx_fifo_if bus();

  uart_rx_fifo #(.CPB(CPB), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .rst       (rst),
    .rx        (rx),
    .m         (bus.master),
    .count     (count),
    .frame_err (frame_err),
    .par_err   (par_err),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [7:0] model_q[$];
  bit rand_ready = 1'b0;
  bit ready_fix  = 1'b0;
  int fe_cnt = 0, pe_cnt = 0, exp_fe = 0, exp_pe = 0;
  bit exp_overrun = 1'b0;
  int start_cyc = 0;
  int rise_cyc = -1;
  logic prev_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // consumer: drives m_ready and checks every pop against the model queue
  always @(negedge clock) begin
    bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
    if (frame_err) fe_cnt++;
    if (par_err) pe_cnt++;
    if (bus.m_valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
    prev_valid = bus.m_valid;
    if (bus.m_valid && bus.m_ready) begin
      chk("pop_avail", 32'(model_q.size() != 0), 1);
      if (model_q.size() != 0) chk("pop_data", bus.m_data, model_q.pop_front());
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit stop_hi, input bit par_flip);
    @(negedge clock);
    rx = 1'b0;
    start_cyc = cyc + 1;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    repeat (CPB) @(negedge clock);
`endif
    if (!stop_hi) exp_fe++;
    else if (par_flip) exp_pe++;
    else if (model_q.size() < DEPTH) model_q.push_back(b);
    else exp_overrun = 1'b1;
    rx = stop_hi;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    ready_fix = 1'b1;
    while ((model_q.size() != 0 || bus.m_valid) && n < 4000) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_left"}, model_q.size(), 0);
    chk({tag, "_count"}, count, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] hi[3];
    hi[0] = 8'h68; hi[1] = 8'h69; hi[2] = 8'h21;
    repeat (3) @(negedge clock);
    rst = 1'b0;
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_data", bus.m_data, 0);
    chk("rst_count", count, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_perr", par_err, 0);
    chk("rst_ovr", overrun, 0);

    ready_fix = 1'b1;
    rise_cyc = -1;
    send_frame(8'h68, 1'b1, 1'b0);
    repeat (4 * CPB) @(negedge clock);
    chk("latency", 32'(rise_cyc - start_cyc), LATENCY);
    chk("single_left", model_q.size(), 0);

    ready_fix = 1'b0;
    for (int i = 0; i < 3; i++) send_frame(hi[i], 1'b1, 1'b0);
    repeat (4) @(negedge clock);
    chk("multi_count", count, 3);
    chk("multi_head", bus.m_data, 8'h68);
    drain("multi");

    ready_fix = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    repeat (4) @(negedge clock);
    chk("ovr_count", count, DEPTH);
    chk("ovr_flag", overrun, exp_overrun);
    drain("ovr");

    @(negedge clock);
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clock);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    chk("glitch_count", count, 0);
    chk("glitch_ferr", fe_cnt, exp_fe);
    send_frame(8'hA5, 1'b1, 1'b0);
    drain("glitch");

    send_frame(8'h55, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (30 * CPB) @(negedge clock);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    chk("break_ferr", fe_cnt, exp_fe);
    chk("break_count", count, 0);
    send_frame(8'h3C, 1'b1, 1'b0);
    drain("break");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    drain("par");
    chk("par_perr", pe_cnt, exp_pe);
`endif

    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 2 * CPB)) @(negedge clock);
      send_frame(b, 1'b1, 1'b0);
    end
    rand_ready = 1'b0;
    drain("rand");
    chk("rand_ferr", fe_cnt, exp_fe);
    chk("rand_perr", pe_cnt, exp_pe);
    chk("rand_ovr", overrun, exp_overrun);

    ready_fix = 1'b0;
    @(negedge clock);
    rx = 1'b0;
    repeat (4 * CPB) @(negedge clock);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clock);
    rst = 1'b0;
    exp_overrun = 1'b0;
    repeat (12 * CPB) @(negedge clock);
    chk("midrst_count", count, 0);
    chk("midrst_valid", bus.m_valid, 0);
    chk("midrst_ovr", overrun, exp_overrun);
    chk("midrst_ferr", fe_cnt, exp_fe);
    send_frame(8'h5A, 1'b1, 1'b0);
    drain("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
